ifu_fetch_buf: RTL and testbench

IFU_FETCH_BUF -- requirements
Module: ifu_fetch_buf

---
 rtl/ifu_fetch_buf.sv | 149 ++++++++++++++
 tb/tb_ifu_fetch_buf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_buf.sv
// Instruction fetch buffer: issues in-order bus reads for the PC, tracks outstanding
// requests in an address queue and delivers {addr, inst, err} through a 2-entry FIFO.
module ifu_fetch_buf #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_err_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_err_o,
    input  logic              inst_ready_i
);

    logic [ADDR_W-1:0] fifo_addr_q [2];
    logic [ADDR_W-1:0] fifo_addr_d [2];
    logic [DATA_W-1:0] fifo_inst_q [2];
    logic [DATA_W-1:0] fifo_inst_d [2];
    logic [1:0]        fifo_err_q;
    logic [1:0]        fifo_err_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;

    logic [ADDR_W-1:0] aq_addr_q [2];
    logic [ADDR_W-1:0] aq_addr_d [2];
    logic              aq_rd_q, aq_rd_d;
    logic              aq_wr_q, aq_wr_d;
    logic [1:0]        out_cnt_q, out_cnt_d;
    logic [1:0]        disc_cnt_q, disc_cnt_d;

    logic              pop;
    logic              issue;
    logic              rsp_drop;
    logic              rsp_take;
    logic [2:0]        credit_used;
    logic [1:0]        pending;
    logic              unused_pc_low;

    assign unused_pc_low = ^pc_i[1:0];

    assign bus_addr_o   = {pc_i[ADDR_W-1:2], 2'b00};
    assign inst_valid_o = ~rst & (fifo_cnt_q != 2'd0);
    assign inst_o       = inst_valid_o ? fifo_inst_q[fifo_rd_q] : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? fifo_addr_q[fifo_rd_q] : '0;
    assign inst_err_o   = inst_valid_o & fifo_err_q[fifo_rd_q];

    assign pop = inst_valid_o & inst_ready_i;

    // Responses still owed to a flushed stream occupy credit too, so live plus
    // discarded requests together never exceed the two slots.
    assign credit_used = {1'b0, out_cnt_q} + {1'b0, disc_cnt_q} + {1'b0, fifo_cnt_q}
                       - {2'b00, pop};
    assign bus_req_o   = ~rst & pc_valid_i & ~flush_i & (credit_used < 3'd2);
    assign issue       = bus_req_o & bus_gnt_i;
    assign pc_ready_o  = issue;

    assign rsp_drop = bus_rvalid_i & (disc_cnt_q != 2'd0);
    assign rsp_take = bus_rvalid_i & (disc_cnt_q == 2'd0) & (out_cnt_q != 2'd0);
    assign pending  = out_cnt_q + disc_cnt_q;

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_inst_d = fifo_inst_q;
        fifo_err_d  = fifo_err_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_cnt_d  = fifo_cnt_q;
        aq_addr_d   = aq_addr_q;
        aq_rd_d     = aq_rd_q;
        aq_wr_d     = aq_wr_q;
        out_cnt_d   = out_cnt_q;
        disc_cnt_d  = disc_cnt_q;

        if (flush_i) begin
            // A response landing in the flush cycle is one fewer to discard later.
            fifo_rd_d  = 1'b0;
            fifo_wr_d  = 1'b0;
            fifo_cnt_d = 2'd0;
            aq_rd_d    = 1'b0;
            aq_wr_d    = 1'b0;
            out_cnt_d  = 2'd0;
            disc_cnt_d = (bus_rvalid_i && pending != 2'd0) ? pending - 2'd1 : pending;
        end else begin
            if (pop) begin
                fifo_rd_d = ~fifo_rd_q;
            end
            if (rsp_drop) begin
                disc_cnt_d = disc_cnt_q - 2'd1;
            end
            if (rsp_take) begin
                fifo_addr_d[fifo_wr_q] = aq_addr_q[aq_rd_q];
                fifo_inst_d[fifo_wr_q] = bus_rdata_i;
                fifo_err_d[fifo_wr_q]  = bus_err_i;
                fifo_wr_d              = ~fifo_wr_q;
                aq_rd_d                = ~aq_rd_q;
            end
            if (issue) begin
                aq_addr_d[aq_wr_q] = bus_addr_o;
                aq_wr_d            = ~aq_wr_q;
            end
            out_cnt_d  = out_cnt_q + {1'b0, issue} - {1'b0, rsp_take};
            fifo_cnt_d = fifo_cnt_q + {1'b0, rsp_take} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            aq_rd_q    <= 1'b0;
            aq_wr_q    <= 1'b0;
            out_cnt_q  <= 2'd0;
            disc_cnt_q <= 2'd0;
        end else begin
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

    // Storage slots need no reset: they are only read while a count marks them valid.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            fifo_addr_q[gi] <= fifo_addr_d[gi];
            fifo_inst_q[gi] <= fifo_inst_d[gi];
            fifo_err_q[gi]  <= fifo_err_d[gi];
            aq_addr_q[gi]   <= aq_addr_d[gi];
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Directed and randomized checks of ifu_fetch_buf against a queue-based model of
// pending responses, discards and delivered instructions.
module tb_ifu_fetch_buf;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_err_o;
    logic        inst_ready_i;

    always #5 clk = ~clk;

    ifu_fetch_buf dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_err_o   (inst_err_o),
        .inst_ready_i (inst_ready_i)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    ent_t        fifo_m[$];
    logic [31:0] pend_m[$];
    int          disc_m;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare combinational view against the model, then advance the model.
    task automatic step();
        bit   exp_v, exp_pop, exp_req, exp_issue;
        ent_t h;
        ent_t n;
        int   tot;
        #1;
        exp_v   = !rst && fifo_m.size() > 0;
        h       = exp_v ? fifo_m[0] : '0;
        exp_pop = exp_v && inst_ready_i;
        exp_req = !rst && pc_valid_i && !flush_i
                  && (pend_m.size() + disc_m + fifo_m.size() - int'(exp_pop) < 2);
        exp_issue = exp_req && bus_gnt_i;
        chk("inst_valid", {63'd0, inst_valid_o}, {63'd0, exp_v});
        chk("inst", {32'd0, inst_o}, {32'd0, exp_v ? h.inst : NOP});
        chk("inst_addr", {32'd0, inst_addr_o}, {32'd0, h.addr});
        chk("inst_err", {63'd0, inst_err_o}, {63'd0, h.err});
        chk("bus_req", {63'd0, bus_req_o}, {63'd0, exp_req});
        chk("pc_ready", {63'd0, pc_ready_o}, {63'd0, exp_issue});
        if (exp_req) chk("bus_addr", {32'd0, bus_addr_o}, {32'd0, pc_i[31:2], 2'b00});
        @(posedge clk);
        if (rst) begin
            fifo_m.delete();
            pend_m.delete();
            disc_m = 0;
        end else if (flush_i) begin
            tot = pend_m.size() + disc_m;
            if (bus_rvalid_i && tot > 0) tot--;
            disc_m = tot;
            pend_m.delete();
            fifo_m.delete();
        end else begin
            if (exp_pop) void'(fifo_m.pop_front());
            if (bus_rvalid_i) begin
                if (disc_m > 0) disc_m--;
                else if (pend_m.size() > 0) begin
                    n.addr = pend_m.pop_front();
                    n.inst = bus_rdata_i;
                    n.err  = bus_err_i;
                    fifo_m.push_back(n);
                end
            end
            if (exp_issue) pend_m.push_back({pc_i[31:2], 2'b00});
        end
        @(negedge clk);
    endtask

    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input logic e,
                             input int waits);
        inst_ready_i = 1'b0;
        pc_i         = a;
        pc_valid_i   = 1'b1;
        bus_gnt_i    = 1'b0;
        repeat (waits) begin
            step();
            chk("wait_req", {63'd0, bus_req_o}, 64'd1);
            chk("wait_addr", {32'd0, bus_addr_o}, {32'd0, a});
            chk("wait_rdy", {63'd0, pc_ready_o}, 64'd0);
        end
        bus_gnt_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        bus_gnt_i  = 1'b0;
        step();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = d;
        bus_err_i    = e;
        step();
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
        chk("fetch_valid", {63'd0, inst_valid_o}, 64'd1);
        chk("fetch_inst", {32'd0, inst_o}, {32'd0, d});
        chk("fetch_addr", {32'd0, inst_addr_o}, {32'd0, a});
        chk("fetch_err", {63'd0, inst_err_o}, {63'd0, e});
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        chk("fetch_single", {63'd0, inst_valid_o}, 64'd0);
    endtask

    task automatic drain();
        pc_valid_i   = 1'b0;
        flush_i      = 1'b0;
        bus_gnt_i    = 1'b0;
        inst_ready_i = 1'b1;
        for (int k = 0; k < 20 && (fifo_m.size() + pend_m.size() + disc_m) > 0; k++) begin
            bus_rvalid_i = (pend_m.size() + disc_m) > 0;
            bus_rdata_i  = $urandom;
            bus_err_i    = 1'b0;
            step();
        end
        bus_rvalid_i = 1'b0;
        step();
        chk("drain_valid", {63'd0, inst_valid_o}, 64'd0);
        inst_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_i = 32'h80; pc_valid_i = 1'b1; flush_i = 1'b0; bus_gnt_i = 1'b1;
        bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0; inst_ready_i = 1'b0;
        disc_m = 0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0; pc_valid_i = 1'b0; bus_gnt_i = 1'b0;
        step();

        // single fetch
        fetch_one(32'h80, 32'h00500093, 1'b0, 0);

        // backpressure fills the FIFO and stalls the PC
        pc_valid_i = 1'b1; bus_gnt_i = 1'b1; pc_i = 32'h00;
        step();
        pc_i = 32'h04;
        step();
        pc_i = 32'h08; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11111111;
        step();
        bus_rdata_i = 32'h22222222;
        step();
        chk("bp_req", {63'd0, bus_req_o}, 64'd0);
        chk("bp_rdy", {63'd0, pc_ready_o}, 64'd0);
        chk("bp_head", {32'd0, inst_addr_o}, 64'h00);
        bus_rvalid_i = 1'b0; inst_ready_i = 1'b1;
        step();
        chk("bp_second", {32'd0, inst_addr_o}, 64'h04);
        chk("bp_resume", {63'd0, pc_ready_o}, 64'd1);
        step();
        drain();

        // flush with two outstanding requests
        pc_valid_i = 1'b1; bus_gnt_i = 1'b1; inst_ready_i = 1'b1; pc_i = 32'h10;
        step();
        pc_i = 32'h14;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; pc_i = 32'h200;
        step();
        pc_valid_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hdeadbeef;
        step();
        step();
        bus_rvalid_i = 1'b0;
        step();
        chk("flush_drop", {63'd0, inst_valid_o}, 64'd0);
        fetch_one(32'h200, 32'h00100073, 1'b0, 0);

        // bus error then clean entry
        fetch_one(32'h40, 32'hcafef00d, 1'b1, 0);
        fetch_one(32'h44, 32'h00000513, 1'b0, 0);

        // wait states on grant
        fetch_one(32'h300, 32'h12345678, 1'b0, 3);

        // reset with one request in flight, then a late response
        pc_i = 32'h500; pc_valid_i = 1'b1; bus_gnt_i = 1'b1;
        step();
        pc_valid_i = 1'b0; bus_gnt_i = 1'b0; rst = 1'b1;
        step();
        chk("rst_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("rst_inst", {32'd0, inst_o}, {32'd0, NOP});
        rst = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0badf00d;
        step();
        bus_rvalid_i = 1'b0;
        step();
        chk("late_rsp", {63'd0, inst_valid_o}, 64'd0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            pc_valid_i   = $urandom_range(0, 3) != 0;
            pc_i         = $urandom;
            bus_gnt_i    = $urandom_range(0, 2) != 0;
            inst_ready_i = $urandom_range(0, 2) != 0;
            flush_i      = $urandom_range(0, 15) == 0;
            bus_rvalid_i = ((pend_m.size() + disc_m) > 0) && ($urandom_range(0, 1) == 1);
            bus_rdata_i  = $urandom;
            bus_err_i    = $urandom_range(0, 7) == 0;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
